// File: rtl/io_mem32_bridge_pkg.sv
// Shared constants for the io-to-mem32 bridge: register map, bit positions,
// FSM state encoding and mem32 direction values.
// No logic; imported by the bridge.
package io_mem32_bridge_pkg;

  // io register offsets
  localparam logic [3:0] c_addr0   = 4'h0;
  localparam logic [3:0] c_addr1   = 4'h1;
  localparam logic [3:0] c_addr2   = 4'h2;
  localparam logic [3:0] c_addr3   = 4'h3;
  localparam logic [3:0] c_data0   = 4'h4;
  localparam logic [3:0] c_data1   = 4'h5;
  localparam logic [3:0] c_data2   = 4'h6;
  localparam logic [3:0] c_data3   = 4'h7;
  localparam logic [3:0] c_byte_en = 4'h8;
  localparam logic [3:0] c_cmd     = 4'h9;  // write side
  localparam logic [3:0] c_status  = 4'h9;  // read side
  localparam logic [3:0] c_ctrl    = 4'hA;

  // command bits (write to c_cmd)
  localparam int c_cmd_start_rd = 0;
  localparam int c_cmd_start_wr = 1;
  localparam int c_cmd_clr_done = 7;

  // status bits (read from c_status)
  localparam int c_stat_busy = 0;
  localparam int c_stat_done = 1;

  // control bits (c_ctrl)
  localparam int c_ctrl_irq_en   = 0;
  localparam int c_ctrl_auto_inc = 1;

  // mem32 direction encoding
  localparam logic c_dir_read  = 1'b0;
  localparam logic c_dir_write = 1'b1;

  typedef enum logic [1:0] {
    st_idle,
    st_req,
    st_rdwait,
    st_done
  } state_t;

endpackage

// File: rtl/io_mem32_bridge.sv
// Purpose: byte-wide io register window that issues single 32-bit mem32 accesses.
// Latency: io_ack one cycle after every strobe; mem32_request rises the cycle after the start write.
// Backpressure: request held until dack_tag matches; busy blocks register writes and new starts.
module io_mem32_bridge
  import io_mem32_bridge_pkg::*;
#(
  parameter logic [7:0] g_tag       = 8'h5A,
  parameter int         g_addr_bits = 26
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [3:0]             io_address,
  input  logic                   io_read,
  input  logic                   io_write,
  input  logic [7:0]             io_wdata,
  output logic [7:0]             io_rdata,
  output logic                   io_ack,
  output logic                   io_irq,
  output logic [g_addr_bits-1:0] mem32_address,
  output logic                   mem32_direction,
  output logic [3:0]             mem32_byte_en,
  output logic [31:0]            mem32_wdata,
  output logic                   mem32_request,
  output logic [7:0]             mem32_tag,
  input  logic [7:0]             mem32_dack_tag,
  input  logic [31:0]            mem32_rdata,
  input  logic                   mem32_rack,
  input  logic [7:0]             mem32_rack_tag
);

  state_t                 state;
  logic [g_addr_bits-1:0] addr_reg;
  logic [g_addr_bits-1:0] addr_next;
  logic [31:0]            addr_ext;
  logic [31:0]            data_reg;
  logic [3:0]             byte_en_reg;
  logic                   irq_en;
  logic                   auto_inc;
  logic                   busy;
  logic                   done;
  logic [7:0]             rd_byte;
  logic                   reg_wr;
  logic                   start;
  logic                   start_dir;
  logic                   dack_ok;
  logic                   rack_ok;

  assign mem32_tag = g_tag;
  assign io_irq    = done & irq_en;
  assign addr_ext  = 32'(addr_reg);

  // Configuration registers only accept writes while no access is in flight.
  assign reg_wr    = io_write && !busy;
  assign start     = reg_wr && (io_address == c_cmd) &&
                     (io_wdata[c_cmd_start_rd] || io_wdata[c_cmd_start_wr]);
  // Read wins when both start bits are set.
  assign start_dir = io_wdata[c_cmd_start_rd] ? c_dir_read : c_dir_write;
  assign dack_ok   = (mem32_dack_tag == g_tag);
  assign rack_ok   = mem32_rack && (mem32_rack_tag == g_tag);

  // Merge one written io byte into the address; bits 1:0 stay zero, bits above the width drop.
  always_comb begin
    addr_next = addr_reg;
    for (int b = 2; b < g_addr_bits; b++) begin
      if ((b / 8) == int'(io_address[1:0])) begin
        addr_next[b] = io_wdata[b % 8];
      end
    end
  end

  // io read multiplexer; unmapped offsets return zero.
  always_comb begin
    rd_byte = 8'h00;
    case (io_address)
      c_addr0:   rd_byte = addr_ext[7:0];
      c_addr1:   rd_byte = addr_ext[15:8];
      c_addr2:   rd_byte = addr_ext[23:16];
      c_addr3:   rd_byte = addr_ext[31:24];
      c_data0:   rd_byte = data_reg[7:0];
      c_data1:   rd_byte = data_reg[15:8];
      c_data2:   rd_byte = data_reg[23:16];
      c_data3:   rd_byte = data_reg[31:24];
      c_byte_en: rd_byte = {4'h0, byte_en_reg};
      c_status:  rd_byte = {6'b0, done, busy};
      c_ctrl:    rd_byte = {6'b0, auto_inc, irq_en};
      default:   rd_byte = 8'h00;
    endcase
  end

  // One-cycle ack for every strobe; read data present only alongside a read ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_ack   <= 1'b0;
      io_rdata <= 8'h00;
    end else begin
      io_ack   <= io_read || io_write;
      io_rdata <= io_read ? rd_byte : 8'h00;
    end
  end

  // Register file plus access FSM; mem32 request fields are registered at start and held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= st_idle;
      addr_reg        <= '0;
      data_reg        <= 32'h0;
      byte_en_reg     <= 4'h0;
      irq_en          <= 1'b0;
      auto_inc        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      mem32_address   <= '0;
      mem32_direction <= c_dir_read;
      mem32_byte_en   <= 4'hF;
      mem32_wdata     <= 32'h0;
      mem32_request   <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (io_address)
          c_addr0, c_addr1, c_addr2, c_addr3: addr_reg <= addr_next;
          c_data0:   data_reg[7:0]   <= io_wdata;
          c_data1:   data_reg[15:8]  <= io_wdata;
          c_data2:   data_reg[23:16] <= io_wdata;
          c_data3:   data_reg[31:24] <= io_wdata;
          c_byte_en: byte_en_reg     <= io_wdata[3:0];
          c_ctrl: begin
            irq_en   <= io_wdata[c_ctrl_irq_en];
            auto_inc <= io_wdata[c_ctrl_auto_inc];
          end
          default: ;
        endcase
      end

      // Clear-done is honoured even while busy; a start in the same write clears it anyway.
      if (io_write && (io_address == c_cmd) && io_wdata[c_cmd_clr_done]) begin
        done <= 1'b0;
      end

      case (state)
        st_idle: begin
          if (start) begin
            mem32_address   <= addr_reg;
            mem32_direction <= start_dir;
            mem32_byte_en   <= byte_en_reg;
            mem32_wdata     <= data_reg;
            mem32_request   <= 1'b1;
            busy            <= 1'b1;
            done            <= 1'b0;
            state           <= st_req;
          end
        end
        st_req: begin
          if (dack_ok) begin
            mem32_request <= 1'b0;
            if (mem32_direction == c_dir_write) begin
              state <= st_done;
            end else if (rack_ok) begin
              // Read data returned in the same cycle as the accept.
              data_reg <= mem32_rdata;
              state    <= st_done;
            end else begin
              state <= st_rdwait;
            end
          end
        end
        st_rdwait: begin
          if (rack_ok) begin
            data_reg <= mem32_rdata;
            state    <= st_done;
          end
        end
        st_done: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (auto_inc) begin
            addr_reg <= addr_reg + g_addr_bits'(4);
          end
          state <= st_idle;
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: doc/io_mem32_bridge.md
Name: io_mem32_bridge

Overview:
- Byte-wide io-bus responder that lets the CPU-side io master issue single 32-bit accesses on the mem32 port, acting as a mem32 initiator.
- Sits on the io bus beside the other peripherals. Its mem32 side connects to the memory system's mem32 responder port (address/direction/byte_en/wdata/request/tag out; dack_tag/rdata/rack/rack_tag in).
- Used for debug and peek/poke access to the 32-bit memory from the byte-wide io space.
- Raises io_irq when an access completes.

Parameters:
- g_tag, 8'h5A: tag driven on mem32_tag; also the value matched on mem32_dack_tag and mem32_rack_tag.
- g_addr_bits, 26: mem32 address width.

Ports:
- clock  in  1  system clock; all logic rising-edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- io_address  in  4  local register select (low bits of the io address).
- io_read  in  1  one-cycle read strobe.
- io_write  in  1  one-cycle write strobe.
- io_wdata  in  8  write data.
- io_rdata  out  8  read data, valid only while io_ack=1, otherwise 0.
- io_ack  out  1  one-cycle acknowledge.
- io_irq  out  1  level interrupt.
- mem32_address  out  g_addr_bits  word address, bits 1:0 always 0.
- mem32_direction  out  1  0=read, 1=write.
- mem32_byte_en  out  4  byte enables for writes.
- mem32_wdata  out  32  write data.
- mem32_request  out  1  request, held until accepted.
- mem32_tag  out  8  constant g_tag.
- mem32_dack_tag  in  8  accept indication; accepted when equal to g_tag.
- mem32_rdata  in  32  read data, valid with rack.
- mem32_rack  in  1  read data strobe.
- mem32_rack_tag  in  8  tag of the returned read data.

Behaviour:
- Reset values:
  - All outputs 0 except mem32_tag=g_tag and mem32_byte_en=4'hF.
  - Registers cleared, state IDLE.
- io handshake:
  - Exactly one io_ack pulse, on the cycle after any io_read or io_write strobe, including unmapped addresses.
  - Unmapped reads return 0; unmapped writes are ignored.
  - The master issues no new strobe before the ack.
- Register map (io_address):
  - 0-3: address bytes, LSB first. Byte 0 bits 1:0 are read-only 0. Bits above g_addr_bits are read as 0.
  - 4-7: data bytes, LSB first. Holds wdata for writes; holds the captured rdata after a read.
  - 8: byte enables, bits 3:0.
  - 9 write: bit0 = start read, bit1 = start write, bit7 = clear done.
  - 9 read: bit0 busy, bit1 done.
  - A: control. bit0 irq enable, bit1 auto-increment.
- Busy rules:
  - Writes to 0-8 and A are ignored while busy.
  - Start commands are ignored while busy.
  - If bit0 and bit1 are both set, read wins.
  - Clear-done and start in the same write: done cleared, then the op starts.
- FSM:
  - IDLE: on start, drive address/direction/byte_en/wdata, assert request, set busy, clear done → REQ.
  - REQ: request stays high until mem32_dack_tag==g_tag; deassert in the same edge.
    - Write: → DONE.
    - Read: → RDWAIT.
    - If mem32_rack with rack_tag==g_tag arrives in that same cycle, capture data → DONE.
  - RDWAIT: on mem32_rack && rack_tag==g_tag, capture mem32_rdata into the data registers → DONE. Rack with any other tag is ignored.
  - DONE (1 cycle):
    - busy=0, done=1.
    - If auto-increment, address += 4, wrapping modulo 2^g_addr_bits.
    - → IDLE.
- Output timing: mem32_request goes high the cycle after the io write strobe. Request outputs are registered and stable for the whole request.
- io_irq = done AND irq_enable. Cleared by clear-done, or by the next start.
- Rack received in IDLE is ignored.
- Asynchronous reset mid-operation:
  - Request drops immediately; state returns to IDLE.
  - A later rack carrying g_tag is ignored.

Decomposition:
- Shared package holds:
  - register offset constants (c_addr0..c_ctrl);
  - status/command bit positions;
  - FSM state enumeration;
  - direction constants c_dir_read=0, c_dir_write=1.
- Single module; no sub-module. The register file and FSM are small enough to keep together.

Test Plan:
- Register readback:
  - Write 0x12,0x34,0x56,0x03 to regs 0-3, read back → 0x10,0x34,0x56,0x03.
  - Each access acked exactly one cycle after its strobe.
- Write op:
  - Setup: address 0x0000100, data 0xDEADBEEF, byte_en 0x5, cmd 0x02.
  - Responder holds off dack for 3 cycles, then returns dack_tag=g_tag.
  - Expect request held 4 cycles with direction=1, byte_en=0x5, wdata=0xDEADBEEF.
  - Status then reads 0x02.
- Read op with a foreign-tag rack in between:
  - cmd 0x01, dack, then rack with tag 0x11 (data 0xFFFFFFFF), then rack with g_tag (data 0xCAFEBABE).
  - Data regs read 0xBE,0xBA,0xFE,0xCA; busy cleared only after the second rack.
- Auto-increment wrap:
  - ctrl=0x03, address 0x3FFFFFC, write op completes.
  - Address reads 0x0000000; io_irq=1.
  - Writing 0x80 to reg 9 drops io_irq.
- Busy protection:
  - While in RDWAIT, write regs 0 and 4 and issue cmd 0x02.
  - Values unchanged, no second request, ack still given.
- Reset mid-op:
  - Assert reset_n low during REQ → request 0 asynchronously.
  - After release, a rack with g_tag causes no data capture and done stays 0.
